muldiv_seq: RTL and testbench

Parametrised iterative multiply/divide unit for the multicycle CPU datapath, the successor to the fixed 32-bit mult_div block that feeds the HI and LO registers. It computes a full-width product, or a quotient and remainder, one bit per clock using shift-add and restoring division. Operands come from the A and B registers, and results are written to HI/LO under a start/busy/done handshake that the control FSM polls. Width and signed-mode support are configurable.

---
 rtl/muldiv_seq_if.sv | 27 ++
 rtl/muldiv_seq.sv | 154 +++++++++++++++
 tb/tb_muldiv_seq.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: operand/command and result bundle between the control FSM and muldiv_seq.
// Latency: none, wires only.
// Backpressure: start is only honoured while busy is low; the master polls busy/done.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_div;
  logic             op_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op_div, op_signed, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op_div, op_signed, a, b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative shift-add multiply / restoring divide feeding HI/LO; MULDIV_SIGNED_EN enables signed mode.
// Latency: WIDTH+2 cycles from start edge to done cycle; divide-by-zero completes in 1 cycle.
// Backpressure: start is accepted only in IDLE; a start while busy is dropped, never queued.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  state_t           state_nxt;

  logic             op_div_q;
  logic [WIDTH-1:0] acc_q;   // product upper half / partial remainder
  logic [WIDTH-1:0] mq_q;    // multiplier -> product lower half / dividend -> quotient
  logic [WIDTH-1:0] md_q;    // multiplicand / divisor magnitude
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             dbz_q;

  logic             b_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  assign b_zero = (bus.b == '0);

`ifdef MULDIV_SIGNED_EN
  logic             neg_res_q;
  logic             neg_rem_q;
  logic [2*WIDTH-1:0] prod;

  // Iterations run on magnitudes; signs are reapplied in FIX.
  assign a_mag = (bus.op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (bus.op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign prod  = {acc_q, mq_q};
`else
  logic unused_op_signed;

  assign unused_op_signed = bus.op_signed;
  assign a_mag = bus.a;
  assign b_mag = bus.b;
`endif

  // One multiply step adds the multiplicand when the multiplier LSB is set; the carry lands in bit WIDTH.
  assign mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, md_q} : {(WIDTH+1){1'b0}});
  // One divide step: shift the next dividend bit into the remainder and trial-subtract on WIDTH+1 bits.
  assign div_shift = {acc_q, mq_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, md_q};

  // Final sign correction: quotient/product by sign difference, remainder by dividend sign.
  always_comb begin
    fix_hi = acc_q;
    fix_lo = mq_q;
`ifdef MULDIV_SIGNED_EN
    if (op_div_q) begin
      if (neg_res_q) fix_lo = -mq_q;
      if (neg_rem_q) fix_hi = -acc_q;
    end else if (neg_res_q) begin
      {fix_hi, fix_lo} = -prod;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: divide by zero short-cuts to DONE, otherwise WIDTH CALC cycles then FIX.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (bus.op_div && b_zero) ? DONE : CALC;
      CALC: if (cnt_q == CNT_W'(1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture in IDLE, one bit per CALC cycle, result registration in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_div_q  <= 1'b0;
      acc_q     <= '0;
      mq_q      <= '0;
      md_q      <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_div_q  <= bus.op_div;
            acc_q     <= '0;
            mq_q      <= a_mag;
            md_q      <= b_mag;
            cnt_q     <= CNT_W'(WIDTH);
            dbz_q     <= bus.op_div && b_zero;
`ifdef MULDIV_SIGNED_EN
            neg_res_q <= bus.op_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_rem_q <= bus.op_signed && bus.a[WIDTH-1];
`endif
          end
        end
        CALC: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (op_div_q) begin
            if (!div_diff[WIDTH]) begin
              acc_q <= div_diff[WIDTH-1:0];
              mq_q  <= {mq_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_q <= div_shift[WIDTH-1:0];
              mq_q  <= {mq_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_q <= mul_sum[WIDTH:1];
            mq_q  <= {mul_sum[0], mq_q[WIDTH-1:1]};
          end
        end
        FIX: begin
          hi_q <= fix_hi;
          lo_q <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and random multiply/divide operations checked against a plain-arithmetic model.
// Latency: checks WIDTH+2 cycles per operation (1 for divide by zero) and the done pulse width.
// Backpressure: exercises dropped mid-operation starts and reset abort.
module tb_muldiv_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_dbz = 1'b0;

  always #5 clk = ~clk;

  muldiv_seq_if #(.WIDTH(W)) mif ();

  muldiv_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: full-width integer arithmetic on sign-extended 64-bit values.
  task automatic model(input bit op_div, input bit op_signed, input logic [W-1:0] a,
                       input logic [W-1:0] b, output logic [W-1:0] e_hi,
                       output logic [W-1:0] e_lo, output logic e_dbz);
    bit eff;
    logic signed [63:0] sa, sb, p, q, r;
`ifdef MULDIV_SIGNED_EN
    eff = op_signed;
`else
    eff = 1'b0;
`endif
    sa = eff ? {{32{a[31]}}, a} : {32'b0, a};
    sb = eff ? {{32{b[31]}}, b} : {32'b0, b};
    e_hi  = m_hi;
    e_lo  = m_lo;
    e_dbz = 1'b0;
    if (op_div && b == '0) begin
      e_dbz = 1'b1;
    end else if (!op_div) begin
      p = sa * sb;
      e_hi = p[63:32];
      e_lo = p[31:0];
    end else begin
      q = sa / sb;
      r = sa % sb;
      e_hi = r[31:0];
      e_lo = q[31:0];
    end
  endtask

  task automatic run_op(input bit op_div, input bit op_signed, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit glitch, input int rst_at);
    logic [W-1:0] e_hi, e_lo;
    logic         e_dbz;
    int           k;
    int           done_cnt;
    model(op_div, op_signed, a, b, e_hi, e_lo, e_dbz);
    @(negedge clk);
    mif.start = 1'b1; mif.op_div = op_div; mif.op_signed = op_signed; mif.a = a; mif.b = b;
    @(negedge clk);
    mif.start = 1'b0;
    check("busy_after_start", mif.busy, 1);
    k = 0;
    while (!mif.done && k < 200) begin
      if (glitch && k == 5) begin
        mif.start = 1'b1; mif.op_div = ~op_div; mif.a = $urandom; mif.b = $urandom;
      end
      if (glitch && k == 6) mif.start = 1'b0;
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", mif.busy, 0);
        check("rst_done", mif.done, 0);
        check("rst_dbz", mif.div_by_zero, 0);
        check("rst_hi", mif.hi, 0);
        check("rst_lo", mif.lo, 0);
        done_cnt = 0;
        for (int i = 0; i < W + 6; i++) begin
          @(negedge clk);
          if (i == 3) rst_n = 1'b1;
          if (mif.done) done_cnt++;
        end
        check("no_done_after_abort", done_cnt, 0);
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        return;
      end
      @(negedge clk);
      k++;
    end
    check("latency", k + 1, e_dbz ? 1 : W + 2);
    check("hi", mif.hi, e_hi);
    check("lo", mif.lo, e_lo);
    check("div_by_zero", mif.div_by_zero, e_dbz);
    @(negedge clk);
    check("done_one_cycle", mif.done, 0);
    check("busy_fall", mif.busy, 0);
    check("hold_hi", mif.hi, e_hi);
    m_hi = e_hi; m_lo = e_lo; m_dbz = e_dbz;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra, rb;
    bit rdiv, rsgn;
    rst_n = 1'b0;
    mif.start = 1'b0; mif.op_div = 1'b0; mif.op_signed = 1'b0; mif.a = '0; mif.b = '0;
    #12;
    check("reset_busy", mif.busy, 0);
    check("reset_done", mif.done, 0);
    check("reset_dbz", mif.div_by_zero, 0);
    check("reset_hi", mif.hi, 0);
    check("reset_lo", mif.lo, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFD, 1'b0, -1);
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
    run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
    run_op(1'b1, 1'b0, 32'd1234, 32'd0, 1'b0, -1);
    run_op(1'b0, 1'b0, 32'd5, 32'd6, 1'b0, -1);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
    run_op(1'b0, 1'b1, 32'd12345, 32'hFFFF_FFF7, 1'b1, -1);
    run_op(1'b1, 1'b1, 32'hDEAD_BEEF, 32'd77, 1'b0, 10);
    run_op(1'b1, 1'b0, 32'd100, 32'd7, 1'b0, -1);

    for (int n = 0; n < 40; n++) begin
      rdiv = 1'($urandom_range(0, 1));
      rsgn = 1'($urandom_range(0, 1));
      ra   = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        2:       rb = {W{1'b1}} - W'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      run_op(rdiv, rsgn, ra, rb, 1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
